// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding, default parameters and counter sizing for rst_seq_ctrl
package rst_seq_pkg;
   typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;
   localparam int DEF_N_STAGES    = 4;
   localparam int DEF_HOLD_CYCLES = 8;
   localparam int DEF_GAP_CYCLES  = 2;
   function automatic int cnt_width(input int hold, input int gap);
      return $clog2((hold > gap ? hold : gap) + 1);
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with synchronous active-high reset
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;
   always_ff @(posedge clk) begin
      if (rst) {meta, q} <= 2'b00;
      else     {meta, q} <= {d, meta};
   end
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered multi-domain reset release sequencer
// RST_SEQ_REQ_SYNC_EN adds a two-flop synchronizer on req (2 cycles of latency).
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int N_STAGES    = DEF_N_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   output logic [N_STAGES-1:0] rst_out,
   output logic                busy,
   output logic                done
);
   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic          req_f;
`ifdef RST_SEQ_REQ_SYNC_EN
   sync_2ff u_sync (.clk(clk), .rst(rst), .d(req), .q(req_f));
`else
   assign req_f = req;
`endif
   // Releases shift a zero in from bit 0; the sequence ends once the top bit is clear.
   always_ff @(posedge clk) begin
      if (rst || req_f) begin
         state   <= ASSERT;
         cnt     <= '0;
         rst_out <= '1;
         busy    <= 1'b1;
         done    <= 1'b0;
      end else begin
         case (state)
            ASSERT, RELEASE: begin
               if (!rst_out[N_STAGES-1]) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (cnt == (state == ASSERT ? HOLD_LAST : GAP_LAST)) begin
                  cnt     <= '0;
                  rst_out <= rst_out << 1;
                  state   <= N_STAGES > 1 ? RELEASE : ASSERT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed self-checking bench for rst_seq_ctrl (N=4, HOLD=8, GAP=2, plus an N=1 instance)
module tb_rst_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [3:0] ro;
   logic       busy, done;
   logic       ro1, busy1, done1;
   int         tests = 0;
   int         fails = 0;
`ifdef RST_SEQ_REQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   always #5 clk = ~clk;

   rst_seq_ctrl #(.N_STAGES(4), .HOLD_CYCLES(8), .GAP_CYCLES(2)) u_dut (
      .clk(clk), .rst(rst), .req(req), .rst_out(ro), .busy(busy), .done(done));
   rst_seq_ctrl #(.N_STAGES(1), .HOLD_CYCLES(3), .GAP_CYCLES(1)) u_one (
      .clk(clk), .rst(rst), .req(req), .rst_out(ro1), .busy(busy1), .done(done1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected {rst_out, busy, done} k edges after the sequence (re)start edge.
   function automatic logic [5:0] exp_of(input int k);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (k < 8 + 2 * i);
      return {r, k <= 14, k == 15};
   endfunction

   task automatic start_req();
      req = 1'b1;
      step();
      req = 1'b0;
      repeat (LAT) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      tests++;
      if ({ro, busy, done} !== 6'b111110) begin
         fails++;
         $display("FAIL reset: got %b want 111110", {ro, busy, done});
      end
      tests++;
      if ({ro1, busy1, done1} !== 3'b110) begin
         fails++;
         $display("FAIL reset_n1: got %b want 110", {ro1, busy1, done1});
      end
      rst = 1'b0;
   endtask

   task automatic test_power_on();
      for (int k = 1; k <= 17; k++) begin
         step();
         tests++;
         if ({ro, busy, done} !== exp_of(k)) begin
            fails++;
            $display("FAIL power_on edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
         end
         tests++;
         if ({ro1, busy1, done1} !== {k < 3, k <= 3, k == 4}) begin
            fails++;
            $display("FAIL power_on_n1 edge %0d: got %b want %b", k, {ro1, busy1, done1}, {k < 3, k <= 3, k == 4});
         end
      end
   endtask

   task automatic test_idle_req();
      int dones = 0;
      req = 1'b1;
      step();
      req = 1'b0;
      for (int j = 0; j < LAT; j++) begin
         tests++;
         if ({ro, busy} !== 5'b00000) begin
            fails++;
            $display("FAIL idle_req_latency %0d: got %b want 00000", j, {ro, busy});
         end
         step();
      end
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) step();
         dones += int'(done);
         tests++;
         if ({ro, busy, done} !== exp_of(k)) begin
            fails++;
            $display("FAIL idle_req edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
         end
      end
      tests++;
      if (dones !== 1) begin
         fails++;
         $display("FAIL idle_req_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_restart();
      int dones = 0;
      start_req();
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 - LAT) req = 1'b1;
         step();
         req = 1'b0;
         dones += int'(done);
         if (k < 11) begin
            tests++;
            if ({ro, busy, done} !== exp_of(k)) begin
               fails++;
               $display("FAIL restart_pre edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
            end
         end
      end
      for (int k = 0; k <= 17; k++) begin
         if (k > 0) step();
         dones += int'(done);
         tests++;
         if ({ro, busy, done} !== exp_of(k)) begin
            fails++;
            $display("FAIL restart edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
         end
      end
      tests++;
      if (dones !== 1) begin
         fails++;
         $display("FAIL restart_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_rst_mid();
      start_req();
      repeat (12) step();
      rst = 1'b1;
      step();
      tests++;
      if ({ro, busy, done} !== 6'b111110) begin
         fails++;
         $display("FAIL rst_mid: got %b want 111110", {ro, busy, done});
      end
      rst = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         step();
         tests++;
         if ({ro, busy, done} !== exp_of(k)) begin
            fails++;
            $display("FAIL rst_mid_rerun edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
         end
      end
   endtask

   task automatic test_req_held();
      req = 1'b1;
      for (int i = 0; i < 20 + LAT; i++) begin
         if (i == 20) req = 1'b0;
         step();
         if (i >= LAT) begin
            tests++;
            if ({ro, busy, done} !== 6'b111110) begin
               fails++;
               $display("FAIL req_held cycle %0d: got %b want 111110", i, {ro, busy, done});
            end
         end
      end
      req = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         step();
         tests++;
         if ({ro, busy, done} !== exp_of(k)) begin
            fails++;
            $display("FAIL req_held_release edge %0d: got %b want %b", k, {ro, busy, done}, exp_of(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_idle_req();
      test_restart();
      test_rst_mid();
      test_req_held();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
